// File: rtl/vector_checker.sv
// vector_checker: on-chip vector table and sequencer for an asynchronous
// Morphle Logic fabric (a ycell or ycell array).
//
// Each vector in the table holds {stim, expect, mask}. A run drives stim
// into the fabric, waits SETTLE cycles for the asynchronous fabric to
// settle, then compares resp against expect under mask. Mismatches are
// counted (saturating) once the vector index reaches SKIP. The first
// counted mismatch is captured, and the run can optionally halt on it.
//
// Ports:
//   clk_i          single clock
//   reset_i        synchronous, active-low reset (table contents survive)
//   wr_en_i        table write strobe (accepted only when not busy)
//   wr_addr_i      table write address
//   wr_data_i      {stim, expect, mask}; mask bit 1 = compare
//   start_i        begin a run (sampled only when idle or done)
//   count_i        vectors to run, clamped to DEPTH
//   halt_on_err_i  stop at the first counted mismatch
//   stim_o         registered stimulus to the fabric
//   resp_i         fabric outputs (asynchronous)
//   busy_o         run in progress
//   done_o         run finished, held until next start or reset
//   pass_o         valid with done; 1 = zero counted errors
//   errors_o       counted mismatches, saturating
//   vec_idx_o      index of the vector currently or last applied
//   fail_idx_o     index of the first counted mismatch
//   fail_resp_o    resp captured at the first counted mismatch
module vector_checker #(
    parameter int STIM_W = 16,
    parameter int RESP_W = 14,
    parameter int DEPTH  = 256,
    parameter int SETTLE = 1,
    parameter int SKIP   = 7,
    parameter int ERR_W  = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       wr_en_i,
    input  logic [AW-1:0]              wr_addr_i,
    input  logic [STIM_W+2*RESP_W-1:0] wr_data_i,
    input  logic                       start_i,
    input  logic [AW:0]                count_i,
    input  logic                       halt_on_err_i,
    output logic [STIM_W-1:0]          stim_o,
    input  logic [RESP_W-1:0]          resp_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic [ERR_W-1:0]           errors_o,
    output logic [AW:0]                vec_idx_o,
    output logic [AW-1:0]              fail_idx_o,
    output logic [RESP_W-1:0]          fail_resp_o
);

    localparam int ENTRY_W = STIM_W + 2 * RESP_W;
    localparam int WCW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int AWP1    = AW + 1;

    localparam logic [AW:0]  DEPTH_L = AWP1'(DEPTH);
    localparam logic [AW:0]  SKIP_L  = AWP1'(SKIP);
    localparam logic [WCW-1:0] WAIT_INIT = WCW'(SETTLE - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRIVE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    function automatic logic [AW:0] clamp_count(input logic [AW:0] c);
        return (c > DEPTH_L) ? DEPTH_L : c;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] e);
        return (&e) ? e : e + 1'b1;
    endfunction

    logic [ENTRY_W-1:0] table_q [DEPTH];

    logic [2:0]        state_q,     state_d;
    logic [STIM_W-1:0] stim_q,      stim_d;
    logic [RESP_W-1:0] exp_q,       exp_d;
    logic [RESP_W-1:0] mask_q,      mask_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              pass_q,      pass_d;
    logic [ERR_W-1:0]  errors_q,    errors_d;
    logic [AW:0]       vec_idx_q,   vec_idx_d;
    logic [AW-1:0]     fail_idx_q,  fail_idx_d;
    logic [RESP_W-1:0] fail_resp_q, fail_resp_d;
    logic [AW:0]       count_q,     count_d;
    logic              halt_q,      halt_d;
    logic [WCW-1:0]    wait_q,      wait_d;

    logic               idle_like;
    logic               wr_ok;
    logic [ENTRY_W-1:0] rd_entry;
    logic               mismatch;
    logic               counted;
    logic               last_vec;
    logic [AW:0]        start_count;

    assign idle_like   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign wr_ok       = wr_en_i && idle_like && ({1'b0, wr_addr_i} < DEPTH_L);
    assign rd_entry    = table_q[vec_idx_q[AW-1:0]];
    assign mismatch    = |((resp_i ^ exp_q) & mask_q);
    assign counted     = mismatch && (vec_idx_q >= SKIP_L);
    assign last_vec    = (vec_idx_q + 1'b1) == count_q;
    assign start_count = clamp_count(count_i);

    // Table storage: not reset, so vectors survive a reset between runs.
    // A write in the same cycle as start lands before the first DRIVE reads.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            table_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        stim_d      = stim_q;
        exp_d       = exp_q;
        mask_d      = mask_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        errors_d    = errors_q;
        vec_idx_d   = vec_idx_q;
        fail_idx_d  = fail_idx_q;
        fail_resp_d = fail_resp_q;
        count_d     = count_q;
        halt_d      = halt_q;
        wait_d      = wait_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    count_d     = start_count;
                    halt_d      = halt_on_err_i;
                    errors_d    = '0;
                    fail_idx_d  = '0;
                    fail_resp_d = '0;
                    pass_d      = 1'b0;
                    done_d      = 1'b0;
                    vec_idx_d   = '0;
                    if (start_count == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_DRIVE;
                        busy_d  = 1'b1;
                    end
                end
            end
            // Stage boundary: table read -> fabric stimulus register.
            S_DRIVE: begin
                stim_d  = rd_entry[ENTRY_W-1 -: STIM_W];
                exp_d   = rd_entry[2*RESP_W-1 -: RESP_W];
                mask_d  = rd_entry[RESP_W-1:0];
                wait_d  = WAIT_INIT;
                state_d = S_WAIT;
            end
            // Stage boundary: fabric settling time, SETTLE cycles.
            S_WAIT: begin
                if (wait_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            // Stage boundary: resp sampled and compared at the end of CHECK.
            S_CHECK: begin
                if (counted) begin
                    errors_d = sat_inc(errors_q);
                    // errors never returns to zero once counted (saturates),
                    // so zero marks the first counted mismatch of the run.
                    if (errors_q == '0) begin
                        fail_idx_d  = vec_idx_q[AW-1:0];
                        fail_resp_d = resp_i;
                    end
                end
                if ((counted && halt_q) || last_vec) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (errors_d == '0);
                end else begin
                    vec_idx_d = vec_idx_q + 1'b1;
                    state_d   = S_DRIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            stim_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            errors_q    <= '0;
            vec_idx_q   <= '0;
            fail_idx_q  <= '0;
            fail_resp_q <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            stim_q      <= stim_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            errors_q    <= errors_d;
            vec_idx_q   <= vec_idx_d;
            fail_idx_q  <= fail_idx_d;
            fail_resp_q <= fail_resp_d;
            wait_q      <= wait_d;
        end
    end

    // Per-run data registers; only meaningful while the FSM uses them.
    always_ff @(posedge clk_i) begin
        exp_q   <= exp_d;
        mask_q  <= mask_d;
        count_q <= count_d;
        halt_q  <= halt_d;
    end

    assign stim_o      = stim_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign errors_o    = errors_q;
    assign vec_idx_o   = vec_idx_q;
    assign fail_idx_o  = fail_idx_q;
    assign fail_resp_o = fail_resp_q;

endmodule
